// File: rtl/led_pattern_ctrl_if.sv
// Mode-change request/acknowledge channel between user-control logic and led_pattern_ctrl.
interface led_pattern_ctrl_if;
  logic       mode_req;
  logic [1:0] mode_sel;
  logic       mode_ack;

  modport master (output mode_req, output mode_sel, input  mode_ack);
  modport slave  (input  mode_req, input  mode_sel, output mode_ack);
endinterface

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: prescaled step tick drives one of four patterns, mode set by req/ack.
// Optional PWM dimmer with brightness port when LED_DIM_EN is defined.
module led_pattern_ctrl #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned TICK_HZ  = 10,
  parameter int unsigned NUM_LED  = 8,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run_en,
  led_pattern_ctrl_if.slave   mode_if,
`ifdef LED_DIM_EN
  input  logic [PWM_BITS-1:0] brightness,
`endif
  output logic                step_tick,
  output logic [NUM_LED-1:0]  LED
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  typedef enum logic [1:0] {M_BLINK, M_CHASE, M_BOUNCE, M_COUNT} mode_t;
  typedef enum logic {LEFT, RIGHT} dir_t;

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  dir_t               dir_q, dir_d;
  logic [NUM_LED-1:0] pat_q, pat_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               accept;
  logic               tick;

  // busy_q blocks re-acceptance of a request still held after its ack.
  assign accept = mode_if.mode_req && !busy_q && !ack_q &&
                  ((state_q == IDLE) || (state_q == RUN));
  assign tick   = (state_q == RUN) && (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    pat_d   = pat_q;
    cnt_d   = '0;
    ack_d   = 1'b0;
    busy_d  = mode_if.mode_req && busy_q;

    if (accept) begin
      mode_d = mode_t'(mode_if.mode_sel);
      ack_d  = 1'b1;
      busy_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        pat_d = '0;
        if (!accept && run_en) state_d = LOAD;
      end
      LOAD: begin
        dir_d   = LEFT;
        state_d = run_en ? RUN : IDLE;
        pat_d   = '0;
        if (run_en) begin
          case (mode_q)
            M_BLINK:  pat_d = '1;
            M_CHASE:  pat_d = NUM_LED'(1);
            M_BOUNCE: pat_d = NUM_LED'(1);
            default:  pat_d = '0;
          endcase
        end
      end
      RUN: begin
        // A request outranks both the tick and continued running.
        if (accept || !run_en) begin
          state_d = (accept && run_en) ? LOAD : IDLE;
          if (!run_en) pat_d = '0;
        end else if (tick) begin
          case (mode_q)
            M_BLINK: pat_d = ~pat_q;
            M_CHASE: pat_d = {pat_q[NUM_LED-2:0], pat_q[NUM_LED-1]};
            M_BOUNCE: begin
              if (dir_q == LEFT) begin
                if (pat_q[NUM_LED-1]) begin
                  pat_d = pat_q >> 1;
                  dir_d = RIGHT;
                end else begin
                  pat_d = pat_q << 1;
                end
              end else begin
                if (pat_q[0]) begin
                  pat_d = pat_q << 1;
                  dir_d = LEFT;
                end else begin
                  pat_d = pat_q >> 1;
                end
              end
            end
            default: pat_d = pat_q + NUM_LED'(1);
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= M_BLINK;
      dir_q   <= LEFT;
      pat_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign mode_if.mode_ack = ack_q;
  assign step_tick        = tick;

`ifdef LED_DIM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LED-1:0]  led_q, led_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    led_d     = pat_q & {NUM_LED{pwm_cnt_q < brightness}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  assign LED = led_q;
`else
  assign LED = pat_q;
`endif

endmodule
